// File: rtl/mux_nx1_rr.sv
// rtl/mux_nx1_rr.sv - N-to-1 round-robin mux with a registered output word.
// Define MUX_NX1_RR_COUNT_EN to build the 16-bit completed-transfer counter.
module mux_nx1_rr #(
   parameter int N = 4,
   parameter int W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic [N-1:0]         in_valid,
   input  logic [N*W-1:0]       in_data,
   output logic [N-1:0]         in_ready,
   output logic                 out_valid,
   output logic [W-1:0]         out_data,
   output logic [$clog2(N)-1:0] out_sel,
   input  logic                 out_ready,
   output logic [15:0]          out_count
);

   localparam int SW = $clog2(N);

   logic [SW-1:0] ptr_q, ptr_d;
   logic          out_valid_q, out_valid_d;
   logic [W-1:0]  out_data_q, out_data_d;
   logic [SW-1:0] out_sel_q, out_sel_d;

   logic [SW-1:0] grant;
   logic          found;
   logic [SW:0]   idx_sum;
   logic          load;
   logic          xfer;
   logic [W-1:0]  grant_data;

   // Search ptr, ptr+1, ... with wrap at N; N need not be a power of two.
   always_comb begin
      grant   = '0;
      found   = 1'b0;
      idx_sum = '0;
      for (int i = 0; i < N; i++) begin
         idx_sum = {1'b0, ptr_q} + (SW+1)'(i);
         if (idx_sum >= (SW+1)'(N))
            idx_sum = idx_sum - (SW+1)'(N);
         if (!found && in_valid[idx_sum[SW-1:0]]) begin
            found = 1'b1;
            grant = idx_sum[SW-1:0];
         end
      end
   end

   always_comb begin
      grant_data = '0;
      for (int k = 0; k < N; k++) begin
         if (grant == SW'(k))
            grant_data = in_data[k*W +: W];
      end
   end

   assign xfer = out_valid_q && out_ready;
   assign load = !rst && en && found && (!out_valid_q || out_ready);

   always_comb begin
      in_ready = '0;
      for (int k = 0; k < N; k++)
         in_ready[k] = load && (grant == SW'(k));
   end

   always_comb begin
      ptr_d       = ptr_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sel_d   = out_sel_q;
      if (load) begin
         out_valid_d = 1'b1;
         out_data_d  = grant_data;
         out_sel_d   = grant;
         ptr_d       = (grant == SW'(N-1)) ? '0 : grant + SW'(1);
      end else if (xfer) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sel_q   <= '0;
      end else begin
         ptr_q       <= ptr_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sel_q   <= out_sel_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sel   = out_sel_q;

`ifdef MUX_NX1_RR_COUNT_EN
   logic [15:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (xfer)
         count_d = count_q + 16'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count_q <= '0;
      else
         count_q <= count_d;
   end

   assign out_count = count_q;
`else
   assign out_count = 16'd0;
`endif

endmodule

// File: tb/tb_mux_nx1_rr.sv
// tb/tb_mux_nx1_rr.sv - directed and random checks of mux_nx1_rr against a behavioural model.
module tb_mux_nx1_rr;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           en;
    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [1:0]     out_sel;
    logic           out_ready;
    logic [15:0]    out_count;

    int checks   = 0;
    int failures = 0;

    int          m_ptr;
    logic        m_valid;
    logic [7:0]  m_data;
    int          m_sel;
    int          m_cnt;

    mux_nx1_rr #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    function automatic int count_exp(input int c);
`ifdef MUX_NX1_RR_COUNT_EN
        return c % 65536;
`else
        return 0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr   = 0;
        m_valid = 1'b0;
        m_data  = 8'h00;
        m_sel   = 0;
        m_cnt   = 0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".out_valid"}, out_valid, m_valid);
        chk({tag, ".out_data"}, out_data, m_data);
        chk({tag, ".out_sel"}, int'(out_sel), m_sel);
        chk({tag, ".out_count"}, int'(out_count), count_exp(m_cnt));
    endtask

    task automatic step(input logic e, input logic [3:0] v, input logic [31:0] d,
                        input logic r, input string tag);
        int g;
        logic ld;
        logic [3:0] exp_ready;
        @(negedge clk);
        en = e; in_valid = v; in_data = d; out_ready = r;
        #1;
        g = -1;
        for (int i = 0; i < N; i++) begin
            if (g < 0 && v[(m_ptr + i) % N]) g = (m_ptr + i) % N;
        end
        ld = e && (g >= 0) && (!m_valid || r);
        exp_ready = ld ? 4'(1 << g) : 4'b0000;
        chk({tag, ".in_ready"}, in_ready, exp_ready);
        @(posedge clk);
        if (m_valid && r) m_cnt++;
        if (ld) begin
            m_valid = 1'b1;
            m_data  = d[g*8 +: 8];
            m_sel   = g;
            m_ptr   = (g + 1) % N;
        end else if (r) begin
            m_valid = 1'b0;
        end
        #1;
        check_outputs(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; in_valid = '0; in_data = '0; out_ready = 1'b0;
        model_reset();
        #2;
        check_outputs("reset_state");
        chk("reset_state.in_ready", in_ready, 4'b0000);
        @(negedge clk);
        rst = 1'b0;

        step(1'b1, 4'b0100, 32'h00A5_0000, 1'b1, "single_ch2");
        chk("single_ch2.data_const", out_data, 8'hA5);
        chk("single_ch2.sel_const", out_sel, 2'd2);
        step(1'b1, 4'b1111, 32'h4433_2211, 1'b1, "ptr_after_ch2");
        chk("ptr_after_ch2.sel_const", out_sel, 2'd3);

        for (int i = 0; i < 5; i++) begin
            step(1'b1, 4'b1111, 32'h4433_2211, 1'b1, "rr_all");
            chk("rr_all.sel_const", int'(out_sel), i % 4);
            chk("rr_all.no_bubble", out_valid, 1'b1);
        end

        step(1'b1, 4'b0011, 32'h0000_BBAA, 1'b0, "bp_hold0");
        step(1'b1, 4'b0011, 32'h0000_BBAA, 1'b0, "bp_hold1");
        step(1'b1, 4'b0011, 32'h0000_BBAA, 1'b1, "bp_release");
        chk("bp_release.valid_const", out_valid, 1'b1);

        step(1'b0, 4'b1111, 32'h1234_5678, 1'b1, "en_low_drain");
        chk("en_low_drain.valid_const", out_valid, 1'b0);
        step(1'b0, 4'b1111, 32'h1234_5678, 1'b1, "en_low_idle");

        step(1'b1, 4'b1000, 32'hC300_0000, 1'b0, "pre_async_rst");
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs("async_rst");
        chk("async_rst.in_ready", in_ready, 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 4'b1010, 32'h7700_6600, 1'b1, "first_after_rst");
        chk("first_after_rst.sel_const", out_sel, 2'd1);

        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 3) != 0), 4'($urandom), $urandom,
                 1'($urandom_range(0, 2) != 0), "random");
        end

        do_reset();
        en = 1'b1; in_valid = 4'b1111; in_data = 32'h0403_0201; out_ready = 1'b1;
        repeat (65538) @(posedge clk);
        #1;
        chk("count_wrap", int'(out_count), count_exp(65537));
        do_reset();
        check_outputs("count_after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_nx1_rr.md
MUX_NX1_RR -- requirements
Module: mux_nx1_rr

Interface
REQ-001 SHALL have parameter N, default 4, meaning number of input channels (N >= 2; power of two not required).
REQ-002 SHALL have parameter W, default 8, meaning data width per channel.
REQ-003 SHALL have port clk  input  1  rising-edge clock (the single clock).
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port en  input  1  enable; low blocks new grants.
REQ-006 SHALL have port in_valid  input  N  per-channel request.
REQ-007 SHALL have port in_data  input  N*W  channel k data at bits [k*W +: W].
REQ-008 SHALL have port in_ready  output  N  one-hot accept strobe, combinational.
REQ-009 SHALL have port out_valid  output  1  output register holds a word.
REQ-010 SHALL have port out_data  output  W  registered winning data.
REQ-011 SHALL have port out_sel  output  $clog2(N)  registered index of source channel.
REQ-012 SHALL have port out_ready  input  1  downstream accept.
REQ-013 SHALL have port out_count  output  16  completed output transfers.

Function
REQ-014 SHALL keep round-robin pointer ptr, range 0..N-1.
REQ-015 SHALL define grant as first k with in_valid[k]=1, searching ptr, ptr+1, ... N-1, 0, ... ptr-1.
REQ-016 SHALL define load = en AND (|in_valid) AND (NOT out_valid OR out_ready).
REQ-017 SHALL drive in_ready[grant]=1 only when load; all other in_ready bits 0; in_ready all 0 when no load.
REQ-018 On load, SHALL register out_data <= in_data[grant], out_sel <= grant, out_valid <= 1 at the next edge (latency 1 cycle).
REQ-019 On load, SHALL set ptr <= grant+1, wrapping N-1 -> 0.
REQ-020 Without load, out_valid AND out_ready SHALL clear out_valid; out_data/out_sel hold last value.
REQ-021 Without load and without out_ready, out_valid/out_data/out_sel/ptr SHALL hold.
REQ-022 Simultaneous drain and load (out_valid=1, out_ready=1, load) SHALL replace the word with no bubble: one transfer per cycle sustained.
REQ-023 en=0 SHALL block loads but SHALL NOT block draining of a held word.
REQ-024 A transfer SHALL occur on any cycle with out_valid=1 and out_ready=1.
REQ-025 ptr SHALL change only on load.

Reset
REQ-026 rst=1 SHALL asynchronously force out_valid=0, out_data=0, out_sel=0, ptr=0, out_count=0.
REQ-027 Reset mid-transfer SHALL discard the held word; no in_ready asserted while rst=1.
REQ-028 After rst release, first grant SHALL search from channel 0.

Configuration
REQ-029 Macro MUX_NX1_RR_COUNT_EN SHALL gate the transfer counter.
REQ-030 With MUX_NX1_RR_COUNT_EN defined, out_count SHALL increment by 1 per transfer (REQ-024), wrapping 0xFFFF -> 0x0000.
REQ-031 Without MUX_NX1_RR_COUNT_EN, out_count SHALL be constant 0 and no counter flops SHALL exist; all other behaviour identical.

Verification
REQ-032 Reset: assert rst mid-cycle with out_valid=1 -> out_valid, out_data, out_sel, out_count all 0 immediately, without waiting for a clock edge.
REQ-033 Single channel: N=4, W=8, en=1, out_ready=1, in_valid=0100, in_data ch2=0xA5 -> in_ready=0100 same cycle; next cycle out_valid=1, out_data=0xA5, out_sel=2; ptr=3.
REQ-034 Round robin: all in_valid=1111 held, out_ready=1 -> out_sel sequence 0,1,2,3,0, one per cycle, no bubbles.
REQ-035 Backpressure: out_valid=1, out_ready=0, in_valid=0011 -> in_ready=0000, output holds; raise out_ready -> next word loaded same edge as drain.
REQ-036 Enable: en=0 with held word and out_ready=1 -> word drains, out_valid=0 next cycle, in_ready=0000 while en=0.
REQ-037 Counter: with MUX_NX1_RR_COUNT_EN, 65537 transfers -> out_count=1; without macro out_count=0 throughout.
